// File: rtl/riscv_hazard_pkg.sv
// Shared types and constants for the forwarding / load-use hazard logic.
//   FWD_REGFILE   : forward select value meaning "read operand from regfile"
//   hist_entry_t  : one producer slot in the EX/post-EX history {valid, rd, avail}
//   AVAIL_ALU     : post-EX stage where an ALU result can first be forwarded
//   entry_avail() : availability stage for a load or an ALU producer
package riscv_hazard_pkg;

    localparam int unsigned FWD_REGFILE = 0;

    // Fixed widths so the struct is usable by every parametrisation;
    // rd is zero-extended from ADDR_W, avail holds LOAD_STAGE (<= 15).
    localparam int unsigned HIST_RD_W = 8;
    localparam int unsigned AVAIL_W   = 4;

    localparam logic [AVAIL_W-1:0] AVAIL_ALU = AVAIL_W'(1);

    // valid means "this slot is a producer": real instruction, writes rd, rd != x0
    typedef struct packed {
        logic                 valid;
        logic [HIST_RD_W-1:0] rd;
        logic [AVAIL_W-1:0]   avail;
    } hist_entry_t;

    function automatic logic [AVAIL_W-1:0] entry_avail(input logic        is_load,
                                                        input int unsigned load_stage);
        return is_load ? AVAIL_W'(load_stage) : AVAIL_ALU;
    endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Combinational check of one ID source register against the producer history.
//   rs, rs_used : source register and whether the instruction really reads it
//   hist        : history, hist[0] = instruction currently in EX (distance 1)
//   hazard      : youngest matching producer's result is not yet forwardable
//   sel         : forward source (0 = regfile, k = post-EX stage k)
module hazard_src_check
    import riscv_hazard_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned SEL_W     = 2
) (
    input  logic [ADDR_W-1:0]               rs,
    input  logic                            rs_used,
    input  hist_entry_t [FWD_DEPTH-1:0]     hist,
    output logic                            hazard,
    output logic [SEL_W-1:0]                sel
);

    logic found;

    // Scan youngest first; the first match decides, older matches are shadowed.
    always_comb begin
        hazard = 1'b0;
        sel    = SEL_W'(FWD_REGFILE);
        found  = 1'b0;
        if (rs_used && (rs != '0)) begin
            for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
                if (!found && hist[i].valid && (hist[i].rd == HIST_RD_W'(rs))) begin
                    found = 1'b1;
                    if (AVAIL_W'(i + 1) < hist[i].avail)
                        hazard = 1'b1;
                    else
                        sel = SEL_W'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding + load-use hazard unit for an in-order pipeline.
//   clk, reset               : rising-edge clock, synchronous active-high reset
//   id_valid                 : ID holds a real instruction
//   id_rs1/id_rs2, *_used    : ID source registers and whether they are read
//   id_rd, id_reg_write      : ID destination and write enable
//   id_is_load               : ID instruction is a load (result at LOAD_STAGE)
//   ex_flush                 : taken branch, kills the ID and EX instructions
//   Pipeline_stall           : hold PC/IF-ID, bubble into EX (combinational)
//   forwardA/forwardB        : registered operand source for the instruction in EX
module fwd_hazard_unit
    import riscv_hazard_pkg::*;
#(
    parameter  int unsigned ADDR_W     = 5,
    parameter  int unsigned FWD_DEPTH  = 2,
    parameter  int unsigned LOAD_STAGE = 2,
    localparam int unsigned SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              ex_flush,
    output logic              Pipeline_stall,
    output logic [SEL_W-1:0]  forwardA,
    output logic [SEL_W-1:0]  forwardB
);

    hist_entry_t [FWD_DEPTH-1:0] hist;
    hist_entry_t                 id_entry;

    logic             haz_a, haz_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             advance;

    hazard_src_check #(
        .ADDR_W    (ADDR_W),
        .FWD_DEPTH (FWD_DEPTH),
        .SEL_W     (SEL_W)
    ) u_chk_rs1 (
        .rs      (id_rs1),
        .rs_used (id_rs1_used),
        .hist    (hist),
        .hazard  (haz_a),
        .sel     (sel_a)
    );

    hazard_src_check #(
        .ADDR_W    (ADDR_W),
        .FWD_DEPTH (FWD_DEPTH),
        .SEL_W     (SEL_W)
    ) u_chk_rs2 (
        .rs      (id_rs2),
        .rs_used (id_rs2_used),
        .hist    (hist),
        .hazard  (haz_b),
        .sel     (sel_b)
    );

    // Producer-ness (reg_write, rd != x0) is folded into valid at entry time.
    always_comb begin
        id_entry       = '0;
        id_entry.valid = id_reg_write && (id_rd != '0);
        id_entry.rd    = HIST_RD_W'(id_rd);
        id_entry.avail = entry_avail(id_is_load, LOAD_STAGE);
    end

    // Flush overrides stall: the stalled ID instruction is killed anyway.
    assign Pipeline_stall = id_valid && !ex_flush && (haz_a || haz_b);
    assign advance        = id_valid && !ex_flush && !(haz_a || haz_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            hist     <= '0;
            forwardA <= '0;
            forwardB <= '0;
        end else begin
            for (int unsigned i = FWD_DEPTH - 1; i >= 1; i--) begin
                hist[i] <= hist[i-1];
                // The instruction leaving EX on a flush was killed there.
                if ((i == 1) && ex_flush)
                    hist[i].valid <= 1'b0;
            end
            hist[0]  <= advance ? id_entry : '0;
            forwardA <= advance ? sel_a : '0;
            forwardB <= advance ? sel_b : '0;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used;
    logic       id_reg_write, id_is_load, ex_flush;

    logic       stall0, stall3;
    logic [1:0] fa0, fb0, fa3, fb3;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        use3     = 1'b0;

    typedef struct {
        string       tag;
        int unsigned fa;
        int unsigned fb;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .ADDR_W     (5),
        .FWD_DEPTH  (2),
        .LOAD_STAGE (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_is_load     (id_is_load),
        .ex_flush       (ex_flush),
        .Pipeline_stall (stall0),
        .forwardA       (fa0),
        .forwardB       (fb0)
    );

    fwd_hazard_unit #(
        .ADDR_W     (5),
        .FWD_DEPTH  (3),
        .LOAD_STAGE (3)
    ) dut3 (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_is_load     (id_is_load),
        .ex_flush       (ex_flush),
        .Pipeline_stall (stall3),
        .forwardA       (fa3),
        .forwardB       (fb3)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One ID cycle: stall is checked combinationally, forwards are queued and
    // compared after the edge moves the instruction into EX.
    task automatic step(input string tag, input logic v,
                        input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic ld,
                        input logic fl, input logic es,
                        input int unsigned efa, input int unsigned efb);
        exp_t e;
        @(negedge clk);
        id_valid = v;   id_rs1 = r1; id_rs1_used = u1;
        id_rs2 = r2;    id_rs2_used = u2;
        id_rd = rd;     id_reg_write = rw; id_is_load = ld; ex_flush = fl;
        #1;
        check({tag, "/stall"}, use3 ? 32'(stall3) : 32'(stall0), 32'(es));
        sb.push_back('{tag, efa, efb});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "/fwdA"}, use3 ? 32'(fa3) : 32'(fa0), e.fa);
        check({e.tag, "/fwdB"}, use3 ? 32'(fb3) : 32'(fb0), e.fb);
    endtask

    task automatic nop(input string tag);
        step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset with a live ID instruction that would otherwise forward/stall
        reset = 1'b1;
        id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd5; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
        id_rd = 5'd5; id_reg_write = 1'b1; id_is_load = 1'b1; ex_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/fwdA", 32'(fa0), 0);
        check("reset/fwdB", 32'(fb0), 0);
        check("reset/stall", 32'(stall0), 0);
        check("reset/stall3", 32'(stall3), 0);
        reset = 1'b0;

        // add x5,x1,x2 ; sub x6,x5,x5
        step("add_x5", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, 0);
        step("sub_d1", 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0, 1, 1);
        nop("n1"); nop("n2");

        // add x5 ; nop ; or x7,x5,x1
        step("add_x5b", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, 0);
        nop("n3");
        step("or_d2", 1, 5'd5, 1, 5'd1, 1, 5'd7, 1, 0, 0, 0, 2, 0);
        nop("n4"); nop("n5");

        // add x5 ; nop ; nop ; or -> beyond forwarding depth
        step("add_x5c", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, 0);
        nop("n6"); nop("n7");
        step("or_d3", 1, 5'd5, 1, 5'd1, 1, 5'd7, 1, 0, 0, 0, 0, 0);
        nop("n8"); nop("n9");

        // lw x5 ; add x6,x5,x0 -> one stall then MEM/WB forward
        step("lw_x5", 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 0);
        step("use_stall", 1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 1, 0, 0);
        step("use_go", 1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 0, 2, 0);
        nop("n10"); nop("n11");

        // unused source after load never stalls
        step("lw_x5u", 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 0);
        step("unused", 1, 5'd5, 0, 5'd3, 1, 5'd6, 1, 0, 0, 0, 0, 0);
        nop("n12"); nop("n13");

        // x0 is never forwarded and never stalls
        step("add_x0", 1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0, 0, 0);
        step("sub_x0", 1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0, 0, 0, 0, 0);
        nop("n14"); nop("n15");

        // youngest producer wins
        step("add5_old", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, 0);
        step("add5_new", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, 0);
        step("use_young", 1, 5'd5, 1, 5'd1, 1, 5'd8, 1, 0, 0, 0, 1, 0);
        nop("n16"); nop("n17");

        // flush in the stall cycle: flush wins, load killed
        step("lw_x5f", 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 0);
        step("use_flush", 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1, 0, 0, 0);
        step("use_after", 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0, 0);
        nop("n18"); nop("n19");

        // reset asserted in a stall cycle clears history
        step("lw_x5r", 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 0);
        reset = 1'b1;
        step("use_rst", 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 1, 0, 0);
        reset = 1'b0;
        step("use_postrst", 1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0, 0);
        nop("n20"); nop("n21"); nop("n22");

        // deeper pipeline: LOAD_STAGE=3, FWD_DEPTH=3
        use3 = 1'b1;
        step("d3_lw", 1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 0);
        step("d3_stall1", 1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 1, 0, 0);
        step("d3_stall2", 1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 1, 0, 0);
        step("d3_go", 1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 0, 3, 0);
        nop("d3_n1");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
